// File: rtl/pic10_ir_queue.sv
// pic10_ir_queue: instruction prefetch FIFO feeding the PIC10 IR register.
// Holds up to DEPTH instruction words. The head word is shown on ir_reg_bus.
// When the queue is empty, ir_reg_bus shows NOP_WORD.
// Optional feature macro: PIC10_IRQ_BYPASS_EN. When it is defined, a word
// loaded into an empty queue is forwarded to ir_reg_bus in the same cycle.
module pic10_ir_queue #(
  parameter int               WIDTH    = 12,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP_WORD = '0,
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_ir_reg,
  input  logic [WIDTH-1:0] program_bus,
  input  logic             advance_ir,
  input  logic             flush,
  output logic [WIDTH-1:0] ir_reg_bus,
  output logic             ir_valid,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             empty;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             bypass_take;

  // Queue control: decide which requests are honoured this cycle.
  // Occupancy flags come from the registered count only.
  always_comb begin
    empty = (count == '0);
    full  = (count == DEPTH_C);
`ifdef PIC10_IRQ_BYPASS_EN
    // A word that is loaded and consumed while the queue is empty never
    // enters storage.
    bypass_take = empty && load_ir_reg && advance_ir && !flush;
`else
    bypass_take = 1'b0;
`endif
    pop    = advance_ir && !empty;
    accept = load_ir_reg && !bypass_take && (!full || pop);
    drop   = load_ir_reg && full && !pop;
  end

  // Head word and valid flag. Storage is masked whenever count is zero.
  always_comb begin
    ir_reg_bus = empty ? NOP_WORD : mem[rd_ptr];
    ir_valid   = !empty;
`ifdef PIC10_IRQ_BYPASS_EN
    if (empty && load_ir_reg && !flush) begin
      ir_reg_bus = program_bus;
      ir_valid   = 1'b1;
    end
`endif
  end

  // Storage write. There is no reset on this array because count gates
  // its visibility.
  always_ff @(posedge clk) begin
    if (!reset && !flush && accept)
      mem[wr_ptr] <= program_bus;
  end

  // Pointers, occupancy count and the sticky overflow flag.
  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pic10_ir_queue.sv
// tb_pic10_ir_queue: directed scenarios with literal expectations, followed
// by a randomized run. Every cycle, the outputs are checked against a
// queue-based reference model.
module tb_pic10_ir_queue;

  localparam int W = 12;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_ir_reg = 1'b0;
  logic [W-1:0]  program_bus = '0;
  logic          advance_ir = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  ir_reg_bus;
  logic          ir_valid;
  logic          full;
  logic [2:0]    count;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq[$];
  bit           m_ov = 1'b0;

  pic10_ir_queue #(.WIDTH(W), .DEPTH(D), .NOP_WORD('0)) dut (
    .clk(clk), .reset(reset), .load_ir_reg(load_ir_reg),
    .program_bus(program_bus), .advance_ir(advance_ir), .flush(flush),
    .ir_reg_bus(ir_reg_bus), .ir_valid(ir_valid), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue that follows the push/pop/flush rules.
  always @(posedge clk) begin
    bit popped;
    if (reset || flush) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
`ifdef PIC10_IRQ_BYPASS_EN
      if (mq.size() == 0 && load_ir_reg && advance_ir) begin
        // The word is consumed directly and is never stored.
      end else
`endif
      begin
        popped = advance_ir && mq.size() > 0;
        if (popped) void'(mq.pop_front());
        if (load_ir_reg) begin
          if (mq.size() < D) mq.push_back(program_bus);
          else m_ov = 1'b1;
        end
      end
    end
  end

  // The per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [W-1:0] e_bus;
    logic         e_val;
    if (chk_en) begin
      e_bus = (mq.size() == 0) ? '0 : mq[0];
      e_val = (mq.size() != 0);
`ifdef PIC10_IRQ_BYPASS_EN
      if (mq.size() == 0 && load_ir_reg && !flush) begin
        e_bus = program_bus;
        e_val = 1'b1;
      end
`endif
      chk("m_bus", 32'(ir_reg_bus), 32'(e_bus));
      chk("m_valid", 32'(ir_valid), 32'(e_val));
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_full", 32'(full), 32'(mq.size() == D));
      chk("m_ovf", 32'(overflow), 32'(m_ov));
    end
  end

  // Apply one cycle of inputs, then return to idle 1 time unit after the edge.
  task automatic step(input bit rs, input bit ld, input logic [W-1:0] pb,
                      input bit adv, input bit fl);
    reset = rs; load_ir_reg = ld; program_bus = pb; advance_ir = adv; flush = fl;
    @(posedge clk); #1;
    reset = 1'b0; load_ir_reg = 1'b0; program_bus = '0; advance_ir = 1'b0; flush = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] bus, input bit val,
                     input int cnt, input bit fu, input bit ov);
    chk({nm, "_bus"}, 32'(ir_reg_bus), 32'(bus));
    chk({nm, "_valid"}, 32'(ir_valid), 32'(val));
    chk({nm, "_count"}, 32'(count), 32'(cnt));
    chk({nm, "_full"}, 32'(full), 32'(fu));
    chk({nm, "_ovf"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    logic [W-1:0] words [4];
    words[0] = 12'h111; words[1] = 12'h222; words[2] = 12'h333; words[3] = 12'h444;
    @(posedge clk); #1;

    // Hold reset for 5 cycles, including a load that must be lost.
    step(1, 1, 12'hFFF, 0, 0);
    chk_en = 1'b1;
    repeat (4) step(1, 0, '0, 0, 0);
    lit("reset", 12'h000, 0, 0, 0, 0);

    // Push one word into the empty queue; it becomes the head one edge later.
    step(0, 1, 12'hABC, 0, 0);
    lit("push1", 12'hABC, 1, 1, 0, 0);
    step(0, 0, '0, 1, 0);
    lit("pop1", 12'h000, 0, 0, 0, 0);
    step(0, 0, '0, 1, 0);
    lit("pop_empty", 12'h000, 0, 0, 0, 0);

    // Fill the queue, then overflow it by one push.
    foreach (words[i]) step(0, 1, words[i], 0, 0);
    lit("fill", 12'h111, 1, 4, 1, 0);
    step(0, 1, 12'h555, 0, 0);
    lit("ovf", 12'h111, 1, 4, 1, 1);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, '0, 1, 0);
      lit("drain", words[i], 1, 4 - i, 0, 1);
    end
    step(0, 0, '0, 1, 0);
    lit("drained", 12'h000, 0, 0, 0, 1);

    // A push and an advance together while full keeps the queue full.
    foreach (words[i]) step(0, 1, words[i], 0, 0);
    step(0, 1, 12'h666, 1, 0);
    lit("full_pa", 12'h222, 1, 4, 1, 1);
    step(0, 0, '0, 1, 0);
    lit("cont1", 12'h333, 1, 3, 0, 1);
    step(0, 0, '0, 1, 0);
    lit("cont2", 12'h444, 1, 2, 0, 1);
    step(0, 0, '0, 1, 0);
    lit("cont3", 12'h666, 1, 1, 0, 1);
    step(0, 1, 12'h888, 1, 0);
    lit("mid_pa", 12'h888, 1, 1, 0, 1);

    // A flush wins over a simultaneous push and advance, and clears overflow.
    step(0, 1, 12'hA01, 0, 0);
    step(0, 1, 12'hA02, 0, 0);
    lit("cnt3", 12'h888, 1, 3, 0, 1);
    step(0, 1, 12'h777, 1, 1);
    lit("flush", 12'h000, 0, 0, 0, 0);
    step(0, 1, 12'h123, 0, 0);
    lit("post_flush", 12'h123, 1, 1, 0, 0);
    step(0, 0, '0, 1, 0);

    // Load and advance together on an empty queue.
    reset = 1'b0; load_ir_reg = 1'b1; program_bus = 12'h9A5; advance_ir = 1'b1; flush = 1'b0;
    #1;
`ifdef PIC10_IRQ_BYPASS_EN
    chk("byp_bus", 32'(ir_reg_bus), 32'h9A5);
    chk("byp_valid", 32'(ir_valid), 32'h1);
`else
    chk("nobyp_bus", 32'(ir_reg_bus), 32'h000);
    chk("nobyp_valid", 32'(ir_valid), 32'h0);
`endif
    @(posedge clk); #1;
    load_ir_reg = 1'b0; program_bus = '0; advance_ir = 1'b0;
`ifdef PIC10_IRQ_BYPASS_EN
    lit("byp_after", 12'h000, 0, 0, 0, 0);
`else
    lit("nobyp_after", 12'h9A5, 1, 1, 0, 0);
    step(0, 0, '0, 1, 0);
`endif

    // Randomized traffic, checked by the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, W'($urandom),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
